// File: rtl/full_sub_cell_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : full_sub_cell_if
//  Purpose  : Operand/result handshake bundle for full_sub_cell.
//             master = producer of operands / consumer of results,
//             slave  = the subtractor cell itself.
//  Revision : 1.0  initial release
// ============================================================================
interface full_sub_cell_if;
  logic in_valid;
  logic in_ready;
  logic a;
  logic b;
  logic bin;
  logic out_valid;
  logic out_ready;
  logic diff;
  logic bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
endinterface
`default_nettype wire

// File: rtl/full_sub_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : full_sub_cell
//  Purpose  : Registered 1-bit full subtractor (a - b - bin) behind a single
//             valid/ready pipeline stage. Leaf cell of ripple-borrow chains.
//  Options  : FULL_SUB_STATS_EN adds parameter STAT_W and a saturating
//             borrow_cnt output counting accepted results with bout=1.
//  Revision : 1.0  initial release
// ============================================================================
module full_sub_cell
`ifdef FULL_SUB_STATS_EN
#(
  parameter int STAT_W = 16
)
`endif
(
  input logic            clk,
  input logic            rst_n,
  full_sub_cell_if.slave bus
`ifdef FULL_SUB_STATS_EN
  ,
  output logic [STAT_W-1:0] borrow_cnt
`endif
);

  logic w_diff;
  logic w_bout;
  logic w_in_ready;
  logic w_accept;
  logic r_out_valid;
  logic r_diff;
  logic r_bout;

  // Subtractor arithmetic on the raw operands; only sampled on accept
  always_comb begin
    w_diff = bus.a ^ bus.b ^ bus.bin;
    w_bout = (~bus.a & bus.b) | (~(bus.a ^ bus.b) & bus.bin);
  end

  // Stage is free when empty or being drained this cycle
  always_comb begin
    w_in_ready = ~r_out_valid | bus.out_ready;
    w_accept   = bus.in_valid & w_in_ready;
  end

  // Output register: load on accept, clear valid on drain, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= 1'b0;
      r_bout      <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_diff      <= w_diff;
      r_bout      <= w_bout;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;

`ifdef FULL_SUB_STATS_EN
  logic [STAT_W-1:0] r_borrow_cnt;
  logic              w_cnt_full;

  assign w_cnt_full = &r_borrow_cnt;

  // Count accepted borrows, sticking at the all-ones value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_borrow_cnt <= '0;
    end else if (w_accept && w_bout && !w_cnt_full) begin
      r_borrow_cnt <= r_borrow_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end

  assign borrow_cnt = r_borrow_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_sub_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_full_sub_cell
//  Purpose  : Self-checking bench for full_sub_cell: truth table, stall,
//             asynchronous reset, throughput, 4-cell ripple chain and (with
//             FULL_SUB_STATS_EN) the borrow counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_full_sub_cell;

  typedef struct packed {
    logic diff;
    logic bout;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  res_t sb[$];
  bit   m_ov;
  int   m_cnt;

  full_sub_cell_if bus_if();

`ifdef FULL_SUB_STATS_EN
  logic [15:0] cnt;
  logic [1:0]  sat_cnt;
  full_sub_cell_if sat_if();

  full_sub_cell u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if.slave),
    .borrow_cnt (cnt)
  );

  full_sub_cell #(.STAT_W(2)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (sat_if.slave),
    .borrow_cnt (sat_cnt)
  );
`else
  full_sub_cell u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );
`endif

  // Ripple chain: each cell's registered bout feeds the next cell's bin
  logic [3:0] ch_a;
  logic [3:0] ch_b;
  logic       ch_bin0;
  logic [3:0] ch_diff;
  logic [3:0] ch_bout;

  for (genvar i = 0; i < 4; i++) begin : g_chain
    full_sub_cell_if cif();
`ifdef FULL_SUB_STATS_EN
    logic [15:0] unused_cnt;
    full_sub_cell u_cell (.clk(clk), .rst_n(rst_n), .bus(cif.slave), .borrow_cnt(unused_cnt));
`else
    full_sub_cell u_cell (.clk(clk), .rst_n(rst_n), .bus(cif.slave));
`endif
    assign cif.in_valid  = 1'b1;
    assign cif.out_ready = 1'b1;
    assign cif.a         = ch_a[i];
    assign cif.b         = ch_b[i];
    assign ch_diff[i]    = cif.diff;
    assign ch_bout[i]    = cif.bout;
    if (i == 0) begin : g_first
      assign cif.bin = ch_bin0;
    end else begin : g_rest
      assign cif.bin = ch_bout[i-1];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference subtraction done with integer arithmetic
  function automatic res_t model(input logic ia, input logic ib, input logic ibin);
    int   v;
    res_t r;
    v      = int'(ia) - int'(ib) - int'(ibin);
    r.diff = ((v & 1) != 0);
    r.bout = (v < 0);
    return r;
  endfunction

  // One clock cycle on the main cell; entered and left at a falling edge
  task automatic cycle(input logic ia, input logic ib, input logic ibin,
                       input logic iv, input logic ordy);
    logic exp_rdy;
    logic acc;
    res_t r;
    bus_if.a         = ia;
    bus_if.b         = ib;
    bus_if.bin       = ibin;
    bus_if.in_valid  = iv;
    bus_if.out_ready = ordy;
    #1;
    exp_rdy = ~m_ov | ordy;
    check("in_ready", {31'd0, bus_if.in_ready}, {31'd0, exp_rdy});
    check("out_valid", {31'd0, bus_if.out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        check("diff", {31'd0, bus_if.diff}, {31'd0, sb[0].diff});
        check("bout", {31'd0, bus_if.bout}, {31'd0, sb[0].bout});
        if (ordy) void'(sb.pop_front());
      end
    end
    acc = iv & exp_rdy;
    if (acc) begin
      r = model(ia, ib, ibin);
      sb.push_back(r);
      if (r.bout && m_cnt < 65535) m_cnt++;
    end
    m_ov = acc | (m_ov & ~ordy);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] v;
    logic [4:0] full;
    checks = 0;
    errors = 0;
    m_ov   = 1'b0;
    m_cnt  = 0;
    rst_n  = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a   = 1'b0;
    bus_if.b   = 1'b0;
    bus_if.bin = 1'b0;
    ch_a    = 4'd0;
    ch_b    = 4'd0;
    ch_bin0 = 1'b0;
`ifdef FULL_SUB_STATS_EN
    sat_if.in_valid  = 1'b0;
    sat_if.out_ready = 1'b1;
    sat_if.a   = 1'b0;
    sat_if.b   = 1'b1;
    sat_if.bin = 1'b0;
`endif

    // Reset state
    #1;
    check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_diff", {31'd0, bus_if.diff}, 32'd0);
    check("rst_bout", {31'd0, bus_if.bout}, 32'd0);
`ifdef FULL_SUB_STATS_EN
    check("rst_cnt", {16'd0, cnt}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive truth table, full throughput
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      cycle(v[2], v[1], v[0], 1'b1, 1'b1);
    end
    cycle(1'bx, 1'bx, 1'bx, 1'b0, 1'b1);
    check("sweep_empty", sb.size(), 32'd0);
`ifdef FULL_SUB_STATS_EN
    check("sweep_cnt", {16'd0, cnt}, 32'd4);
    check("sweep_cnt_model", {16'd0, cnt}, m_cnt);
`endif

    // Backpressure: hold result 001 -> (1,1) while offering 100
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("stall_diff", {31'd0, bus_if.diff}, 32'd1);
    check("stall_bout", {31'd0, bus_if.bout}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'bx, 1'bx, 1'bx, 1'b0, 1'b1);
    cycle(1'bx, 1'bx, 1'bx, 1'b0, 1'b1);

    // Asynchronous reset with a (1,1) result held
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    check("pre_rst_valid", {31'd0, bus_if.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("arst_diff", {31'd0, bus_if.diff}, 32'd0);
    check("arst_bout", {31'd0, bus_if.bout}, 32'd0);
    check("arst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
`ifdef FULL_SUB_STATS_EN
    check("arst_cnt", {16'd0, cnt}, 32'd0);
    m_cnt = 0;
`endif
    sb.delete();
    m_ov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'bx, 1'bx, 1'bx, 1'b0, 1'b1);

    // Back-to-back throughput: 4 accepts, results in order
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'bx, 1'bx, 1'bx, 1'b0, 1'b1);
    cycle(1'bx, 1'bx, 1'bx, 1'b0, 1'b1);
    check("b2b_empty", sb.size(), 32'd0);

    // Ripple chain: hold operands until the borrow has rippled through
    ch_a = 4'd2; ch_b = 4'd3; ch_bin0 = 1'b0;
    full = {1'b0, ch_a} - {1'b0, ch_b} - {4'd0, ch_bin0};
    repeat (5) @(negedge clk);
    check("chain_2m3_diff", {28'd0, ch_diff}, {28'd0, full[3:0]});
    check("chain_2m3_bout", {31'd0, ch_bout[3]}, {31'd0, full[4]});
    check("chain_2m3_const", {27'd0, ch_bout[3], ch_diff}, 32'h1F);
    ch_a = 4'd6; ch_b = 4'd8; ch_bin0 = 1'b0;
    full = {1'b0, ch_a} - {1'b0, ch_b} - {4'd0, ch_bin0};
    repeat (5) @(negedge clk);
    check("chain_6m8_diff", {28'd0, ch_diff}, {28'd0, full[3:0]});
    check("chain_6m8_bout", {31'd0, ch_bout[3]}, {31'd0, full[4]});
    check("chain_6m8_const", {27'd0, ch_bout[3], ch_diff}, 32'h1E);

`ifdef FULL_SUB_STATS_EN
    // Saturation of a 2-bit counter after 5 borrow accepts
    sat_if.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    sat_if.in_valid = 1'b0;
    @(negedge clk);
    check("sat_cnt", {30'd0, sat_cnt}, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/full_sub_cell.md
Name: full_sub_cell

Overview:
- Registered 1-bit full subtractor: computes a − b − bin and produces difference and borrow-out.
- Wrapped in a single-stage valid/ready pipeline register.
- Leaf cell for ripple-borrow subtractors. A chain carries each cell's bout into the next cell's bin.
- Clocked by clk; asynchronous active-low reset rst_n.

Parameters:
- STAT_W, 16, width of the borrow-event counter. Used only when FULL_SUB_STATS_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands a/b/bin are valid this cycle.
- in_ready  output  1  cell can accept operands this cycle.
- a  input  1  minuend bit.
- b  input  1  subtrahend bit.
- bin  input  1  borrow-in from the less-significant cell.
- out_valid  output  1  diff/bout hold a valid result.
- out_ready  input  1  downstream accepts result this cycle.
- diff  output  1  difference bit: a ^ b ^ bin.
- bout  output  1  borrow-out: (~a & b) | (~(a ^ b) & bin).
- borrow_cnt  output  STAT_W  count of accepted results with bout=1. Present only with FULL_SUB_STATS_EN.

Behaviour:
- Arithmetic is combinational on the inputs and captured into output registers on accept. Truth table (a,b,bin -> diff,bout):
  - 000->00, 001->11, 010->11, 011->01
  - 100->10, 101->00, 110->00, 111->11
- in_ready = ~out_valid | out_ready. This is combinational, so a full pipeline runs at one result per cycle.
- Accept: in_valid & in_ready on a rising clk edge. diff/bout load the computed values and out_valid sets to 1. Latency is exactly 1 cycle.
- Output handshake: out_valid & out_ready with no new accept in the same cycle clears out_valid on the next edge.
- Simultaneous accept and drain in the same cycle: new result loads and out_valid stays 1.
- Backpressure: when out_valid=1 and out_ready=0, diff, bout and out_valid hold and in_ready=0. Inputs are ignored.
- When out_valid=0, diff/bout keep their last values. Consumers must qualify them with out_valid.
- Reset: when rst_n goes low, out_valid=0, diff=0, bout=0 and borrow_cnt=0 immediately, without waiting for clk. Any result in flight is discarded.
- Reset release is synchronous to the next clk edge. in_ready=1 during reset and from the first cycle after.
- X on a/b/bin while in_valid=0 has no effect on state.

Optional Feature:
- Macro FULL_SUB_STATS_EN.
- Defined:
  - borrow_cnt port and register exist.
  - Increments by 1 on each accept whose computed bout=1.
  - Saturates at 2^STAT_W−1 and never wraps.
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Exhaustive: apply all 8 a/b/bin combos with in_valid=1 and out_ready=1 held. Each result appears one cycle later, matching the truth table, e.g. a=0,b=1,bin=0 -> diff=1,bout=1; a=1,b=0,bin=0 -> diff=1,bout=0; a=1,b=1,bin=1 -> diff=1,bout=1.
- Backpressure: accept a=0,b=0,bin=1, then hold out_ready=0 for 3 cycles while driving a=1,b=0,bin=0.
  - During the stall: diff=1, bout=1, out_valid=1, in_ready=0.
  - After out_ready=1: the held result drains, and the next result is diff=1, bout=0.
- Asynchronous reset: assert rst_n=0 mid-cycle while out_valid=1 with diff=1,bout=1. diff=0, bout=0, out_valid=0 immediately, without a clk edge. After release, the first accept yields a correct result one cycle later.
- Back-to-back throughput: 4 consecutive accepts with out_ready=1 -> out_valid stays 1 for 4 cycles with results in order.
- Ripple composition: chain 4 cells, with bout feeding the next cell's bin through the registered stage (time-aligned by the bench).
  - a=2, b=3, bin0=0 -> diff nibble 1111, final bout=1.
  - a=6, b=8 -> diff nibble 1110, final bout=1.
- With FULL_SUB_STATS_EN: after the exhaustive sweep borrow_cnt=4. With STAT_W=2 and 5 borrow accepts, borrow_cnt saturates at 3.
